// File: rtl/seu_counter_ctrl_pkg.sv
// Shared definitions for the SEU counter block: readout FSM states,
// a ceiling-log2 helper and the default counter width and saturation value.
package seu_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CLEAR = 2'd2,
    ACK   = 2'd3
  } rdState_t;

  localparam int DEF_CNTWIDTH = 8;
  localparam int SAT_MAX      = (2 ** DEF_CNTWIDTH) - 1;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res++;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/seu_sat_counter.sv
// One saturating error counter with a sticky overflow flag. A clear that
// coincides with an increment leaves 1 so that error is not lost.
module seu_sat_counter
  import seu_counter_ctrl_pkg::*;
#(
  parameter int CNTWIDTH = DEF_CNTWIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                clr,
  output logic [CNTWIDTH-1:0] cnt,
  output logic                sat
);

  localparam logic [CNTWIDTH-1:0] CntMax = {CNTWIDTH{1'b1}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= inc ? CNTWIDTH'(1) : '0;
      sat <= 1'b0;
    end else if (inc) begin
      // At the ceiling the value holds and the event is recorded in sat.
      if (cnt == CntMax) sat <= 1'b1;
      else               cnt <= cnt + CNTWIDTH'(1);
    end
  end

endmodule

// File: rtl/seu_counter_ctrl.sv
// Per-source SEU counters with a single req/ack readout port (optional
// clear-on-read) and a registered threshold interrupt.
module seu_counter_ctrl
  import seu_counter_ctrl_pkg::*;
#(
  parameter int NSRC     = 4,
  parameter int CNTWIDTH = 8,
  parameter int SELW     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NSRC-1:0]     err,
  input  logic                rd_req,
  input  logic [SELW-1:0]     rd_sel,
  input  logic                rd_clear,
  output logic                rd_ack,
  output logic [CNTWIDTH-1:0] rd_data,
  output logic                rd_sat,
  output logic                rd_err,
  input  logic [CNTWIDTH-1:0] thresh,
  output logic                irq
);

  // rd_req/rd_ack is a 4-phase handshake: the master raises rd_req with
  // rd_sel/rd_clear stable, holds it until rd_ack, then drops it; rd_ack stays
  // high (with rd_data/rd_sat/rd_err stable) until rd_req is seen low.
  rdState_t            state;
  rdState_t            stateNext;
  logic [SELW-1:0]     selQ;
  logic                clrQ;
  logic [NSRC-1:0]     clrVec;
  logic [NSRC-1:0]     satVec;
  logic [CNTWIDTH-1:0] cntArr [NSRC];
  logic                selValid;
  logic [CNTWIDTH-1:0] selCnt;
  logic                selSat;
  logic                anyGe;

  for (genvar i = 0; i < NSRC; i++) begin : gCnt
    seu_sat_counter #(.CNTWIDTH(CNTWIDTH)) uCnt (
      .clk (clk),
      .rst (rst),
      .inc (err[i]),
      .clr (clrVec[i]),
      .cnt (cntArr[i]),
      .sat (satVec[i])
    );
  end

  // Readout mux, clear decode and threshold compare.
  always_comb begin
    selValid = (int'(selQ) < NSRC);
    selCnt   = '0;
    selSat   = 1'b0;
    clrVec   = '0;
    anyGe    = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (int'(selQ) == i) begin
        selCnt    = cntArr[i];
        selSat    = satVec[i];
        clrVec[i] = (state == CLEAR);
      end
      if (cntArr[i] >= thresh) anyGe = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (rd_req) stateNext = READ;
      READ:    stateNext = (clrQ && selValid) ? CLEAR : ACK;
      CLEAR:   stateNext = ACK;
      ACK:     if (!rd_req) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign rd_ack = (state == ACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      selQ    <= '0;
      clrQ    <= 1'b0;
      rd_data <= '0;
      rd_sat  <= 1'b0;
      rd_err  <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (state == IDLE && rd_req) begin
        selQ <= rd_sel;
        clrQ <= rd_clear;
      end
      // An out-of-range index yields zero data (selCnt/selSat stay 0).
      if (state == READ) begin
        rd_data <= selCnt;
        rd_sat  <= selSat;
        rd_err  <= !selValid;
      end
      irq <= (thresh != '0) && anyGe;
    end
  end

endmodule

// File: tb/tb_seu_counter_ctrl.sv
// Self-checking bench for seu_counter_ctrl: directed scenarios plus a random
// phase, checked against an integer-arithmetic model of the counters and irq.
module tb_seu_counter_ctrl;

  localparam int NSRC     = 4;
  localparam int CNTWIDTH = 8;
  localparam int SELW     = 3;
  localparam int SATMAX   = (2 ** CNTWIDTH) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NSRC-1:0]     err = '0;
  logic                rd_req = 1'b0;
  logic [SELW-1:0]     rd_sel = '0;
  logic                rd_clear = 1'b0;
  logic                rd_ack;
  logic [CNTWIDTH-1:0] rd_data;
  logic                rd_sat;
  logic                rd_err;
  logic [CNTWIDTH-1:0] thresh = '0;
  logic                irq;

  int passCnt  = 0;
  int totalCnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  seu_counter_ctrl #(.NSRC(NSRC), .CNTWIDTH(CNTWIDTH), .SELW(SELW)) dut (
    .clk      (clk),
    .rst      (rst),
    .err      (err),
    .rd_req   (rd_req),
    .rd_sel   (rd_sel),
    .rd_clear (rd_clear),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .rd_sat   (rd_sat),
    .rd_err   (rd_err),
    .thresh   (thresh),
    .irq      (irq)
  );

  // Reference model: plain integer counts, sticky sat bits, registered irq.
  int mCnt [NSRC];
  bit mSat [NSRC];
  bit irqExp;
  int mClrSel = -1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        mCnt[i] = 0;
        mSat[i] = 1'b0;
      end
      irqExp = 1'b0;
    end else begin
      bit anyHit;
      anyHit = 1'b0;
      for (int i = 0; i < NSRC; i++)
        if (thresh != 0 && mCnt[i] >= int'(thresh)) anyHit = 1'b1;
      irqExp = anyHit;
      for (int i = 0; i < NSRC; i++) begin
        if (i == mClrSel) begin
          mCnt[i] = err[i] ? 1 : 0;
          mSat[i] = 1'b0;
        end else if (err[i]) begin
          if (mCnt[i] == SATMAX) mSat[i] = 1'b1;
          else                   mCnt[i] = mCnt[i] + 1;
        end
      end
    end
  end

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick(input logic [NSRC-1:0] e);
    err = e;
    @(negedge clk);
    chk("irq", 32'(irq), 32'(irqExp));
  endtask

  task automatic doRead(input int sel, input bit clr, input logic [NSRC-1:0] bgErr,
                        input logic [NSRC-1:0] clrCycErr, output int gotData, output int gotSat);
    int expData;
    int expSat;
    int expErr;
    bit willClear;
    rd_req   = 1'b1;
    rd_sel   = SELW'(sel);
    rd_clear = clr;
    err      = bgErr;
    @(negedge clk);
    chk("ack_in_read", 32'(rd_ack), 0);
    expErr  = (sel >= NSRC) ? 1 : 0;
    expData = 0;
    expSat  = 0;
    if (expErr == 0) begin
      expData = mCnt[sel];
      expSat  = int'(mSat[sel]);
    end
    // Changes after acceptance must have no effect.
    rd_sel    = ~rd_sel;
    rd_clear  = ~clr;
    willClear = clr && (expErr == 0);
    @(negedge clk);
    if (willClear) begin
      chk("ack_in_clear", 32'(rd_ack), 0);
      err     = clrCycErr;
      mClrSel = sel;
      @(negedge clk);
      mClrSel = -1;
      err     = bgErr;
    end
    chk("ack", 32'(rd_ack), 1);
    chk("rd_data", 32'(rd_data), 32'(expData));
    chk("rd_sat", 32'(rd_sat), 32'(expSat));
    chk("rd_err", 32'(rd_err), 32'(expErr));
    gotData = int'(rd_data);
    gotSat  = int'(rd_sat);
    @(negedge clk);
    chk("ack_hold", 32'(rd_ack), 1);
    chk("rd_data_hold", 32'(rd_data), 32'(expData));
    rd_req = 1'b0;
    @(negedge clk);
    chk("ack_drop", 32'(rd_ack), 0);
    chk("irq", 32'(irq), 32'(irqExp));
  endtask

  initial begin : main
    int d;
    int s;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(rd_ack), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_sat", 32'(rd_sat), 0);
    chk("rst_err", 32'(rd_err), 0);
    chk("rst_irq", 32'(irq), 0);
    rst = 1'b0;
    tick('0);

    // threshold interrupt on source 3
    thresh = 8'd3;
    repeat (3) tick(4'b1000);
    chk("irq_before_rise", 32'(irq), 0);
    tick('0);
    chk("irq_rise", 32'(irq), 1);
    doRead(3, 1'b1, '0, '0, d, s);
    chk("irq_src_val", 32'(d), 3);
    repeat (2) tick('0);
    chk("irq_fall", 32'(irq), 0);
    thresh = '0;

    // basic count and non-destructive reads
    repeat (5) tick(4'b0100);
    doRead(2, 1'b0, '0, '0, d, s);
    chk("cnt2_first", 32'(d), 5);
    chk("cnt2_sat", 32'(s), 0);
    doRead(2, 1'b0, '0, '0, d, s);
    chk("cnt2_second", 32'(d), 5);

    // saturation then clear-on-read
    repeat (300) tick(4'b0001);
    doRead(0, 1'b0, '0, '0, d, s);
    chk("sat_data", 32'(d), 255);
    chk("sat_flag", 32'(s), 1);
    doRead(0, 1'b1, '0, '0, d, s);
    chk("sat_clr_data", 32'(d), 255);
    doRead(0, 1'b0, '0, '0, d, s);
    chk("after_clr_data", 32'(d), 0);
    chk("after_clr_sat", 32'(s), 0);

    // error arriving in the clear cycle survives
    repeat (7) tick(4'b0010);
    doRead(1, 1'b1, '0, 4'b0010, d, s);
    chk("clr_race_data", 32'(d), 7);
    doRead(1, 1'b0, '0, '0, d, s);
    chk("clr_race_next", 32'(d), 1);

    // out-of-range select, with and without clear
    doRead(5, 1'b0, '0, '0, d, s);
    chk("oor_data", 32'(d), 0);
    doRead(5, 1'b1, '0, '0, d, s);
    doRead(2, 1'b0, '0, '0, d, s);
    chk("oor_untouched", 32'(d), 5);

    // random phase against the model
    for (int it = 0; it < 40; it++) begin
      thresh = CNTWIDTH'($urandom_range(0, 12));
      repeat ($urandom_range(0, 6)) tick(NSRC'($urandom_range(0, (2 ** NSRC) - 1)));
      doRead($urandom_range(0, 5), 1'($urandom_range(0, 1)),
             NSRC'($urandom_range(0, (2 ** NSRC) - 1)),
             NSRC'($urandom_range(0, (2 ** NSRC) - 1)), d, s);
    end
    thresh = '0;

    // reset while holding ACK
    repeat (3) tick(4'b0100);
    rd_req   = 1'b1;
    rd_sel   = 3'd2;
    rd_clear = 1'b0;
    err      = '0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_ack", 32'(rd_ack), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ack", 32'(rd_ack), 0);
    chk("async_rst_data", 32'(rd_data), 0);
    chk("async_rst_sat", 32'(rd_sat), 0);
    chk("async_rst_err", 32'(rd_err), 0);
    chk("async_rst_irq", 32'(irq), 0);
    @(negedge clk);
    rst = 1'b0;
    doRead(2, 1'b0, '0, '0, d, s);
    chk("post_rst_cnt", 32'(d), 0);

    // final report
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/seu_counter_ctrl.md
Name: seu_counter_ctrl

Overview:
- Collects TMR-mismatch error pulses from NSRC triplicated pipeline segments into per-source saturating SEU counters.
- Serves a single req/ack readout port with optional clear-on-read, so a slow-control master can read the counters one at a time.
- Flags a threshold interrupt when any counter reaches a programmable level.
- Sits beside the triplicated datapath blocks; takes their voted error outputs and exports status to slow control.

Parameters:
- NSRC, 4, number of error sources/counters (1..16)
- CNTWIDTH, 8, width of each counter
- SELW, 2, width of rd_sel (must satisfy 2**SELW >= NSRC)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- err  input  NSRC  per-source error strobe, synchronous to clk; counts once per cycle high
- rd_req  input  1  read request, 4-phase; held high until rd_ack seen
- rd_sel  input  SELW  counter index; sampled only when a request is accepted
- rd_clear  input  1  clear selected counter after read; sampled with rd_sel
- rd_ack  output  1  read complete; held high while rd_req high
- rd_data  output  CNTWIDTH  captured counter value, valid while rd_ack=1
- rd_sat  output  1  selected counter was saturated at capture
- rd_err  output  1  rd_sel >= NSRC at acceptance
- thresh  input  CNTWIDTH  interrupt threshold; 0 disables
- irq  output  1  level, high while any counter >= thresh (thresh != 0)

Behaviour:
- Reset (async assert, sync release): all counters and sat flags 0; FSM in IDLE; rd_ack, rd_data, rd_sat, rd_err, irq all 0.
- Counting: err[i] high in cycle t → cnt[i] incremented at edge ending t, visible at t+1.
  - Saturates at 2**CNTWIDTH-1; further errors hold the value and set the sticky sat[i].
  - No wrap-around.
- FSM states IDLE, READ, CLEAR, ACK.
  - IDLE: on rd_req=1, latch rd_sel and rd_clear → READ.
  - READ: capture cnt[sel] and sat[sel] into rd_data/rd_sat, or 0/0 with rd_err=1 if sel out of range.
    - Next state CLEAR if latched clear and sel valid; otherwise ACK.
  - CLEAR: cnt[sel] and sat[sel] are cleared.
    - If err[sel]=1 in the same cycle, cnt[sel] becomes 1, not 0: no error lost.
    - Next state ACK.
  - ACK: rd_ack=1; rd_data, rd_sat, rd_err held stable. When rd_req=0 → IDLE, and rd_ack drops the next cycle.
- Latency: rd_req first high in cycle t → rd_ack high from t+2 (no clear) or t+3 (clear).
- Captured value includes errors counted up to and including cycle t+1's edge; errors in the READ cycle itself are excluded from rd_data.
- rd_req dropping before rd_ack is a protocol violation.
  - The FSM completes the transaction regardless and returns to IDLE from ACK immediately.
- rd_sel and rd_clear changes outside IDLE acceptance are ignored.
- Counting continues in every FSM state for all sources.
- irq: registered compare; goes high the cycle after any cnt >= thresh and low the cycle after the condition clears.
- Reset mid-transaction: immediate return to IDLE; rd_ack and all outputs go to 0.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, READ, CLEAR, ACK)
  - a clog2 helper function
  - the SAT_MAX constant expression
- Natural sub-module: seu_sat_counter.
  - Ports: clk, rst, inc, clr, cnt, sat. clr with inc gives 1.
  - Instantiated NSRC times by generate.
- Arbitration and readout FSM live in the top.

Test Plan:
- Reset then err[2] high for 5 cycles → cnt[2]=5. Read sel=2, clear=0 → rd_ack at t+2, rd_data=5, rd_sat=0; a second read still returns 5.
- err[0] high for 300 cycles (CNTWIDTH=8) → read sel=0 gives rd_data=255, rd_sat=1. Read with clear=1 → next read gives 0/0.
- cnt[1]=7, read sel=1 clear=1 with err[1]=1 exactly in the CLEAR cycle → rd_data=7; next read gives rd_data=1.
- thresh=3, err[3] pulsed 3 times → irq rises one cycle after the third count. Clear-read of sel=3 → irq falls. thresh=0 → irq stays 0.
- Read sel=5 with NSRC=4 → rd_err=1, rd_data=0, no counter modified, rd_ack asserted normally.
- rst asserted while in ACK with rd_req high → rd_ack, rd_data and counters go to 0 asynchronously. After release with rd_req still high, a new transaction is accepted.
